retire_scoreboard: RTL
======================

Name: retire_scoreboard

Overview:
- In-order, circular-buffer scoreboard between issue and commit.
- Issue allocates one entry per cycle and returns a transaction ID.
- Functional units write back results out of order by ID.
- Commit retires up to NR_COMMIT_PORTS oldest completed entries per cycle.
- Sized by the core configuration: 8 scoreboard entries, 2 commit ports, 64-bit XLEN.

Parameters:
- NR_ENTRIES, 8: buffer depth; power of two, at least 2.
- NR_COMMIT_PORTS, 2: commit ports per cycle; must be 1 or 2.
- NR_WB_PORTS, 2: writeback ports.
- XLEN, 64: result data width.
- PAYLOAD_W, 32: opaque per-instruction payload width (opcode, rd, etc.).
- IDW, $clog2(NR_ENTRIES): transaction ID width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries.
- issue_valid_i  in  1  issue request.
- issue_payload_i  in  PAYLOAD_W  instruction payload.
- issue_ready_o  out  1  entry available.
- issue_trans_id_o  out  IDW  ID granted to the current issue.
- wb_valid_i  in  NR_WB_PORTS  writeback strobe, one per port.
- wb_trans_id_i  in  NR_WB_PORTS*IDW  target ID per port.
- wb_data_i  in  NR_WB_PORTS*XLEN  result per port.
- wb_ex_i  in  NR_WB_PORTS  exception flag per port.
- commit_valid_o  out  NR_COMMIT_PORTS  entry ready to retire, per port.
- commit_payload_o  out  NR_COMMIT_PORTS*PAYLOAD_W  retiring payload.
- commit_data_o  out  NR_COMMIT_PORTS*XLEN  retiring result.
- commit_ex_o  out  NR_COMMIT_PORTS  retiring exception flag.
- commit_ack_i  in  NR_COMMIT_PORTS  commit consumes the entry on that port.
- occupancy_o  out  IDW+1  number of busy entries.

Behaviour:
- Storage per entry: busy, done, ex, payload, data.
- State: head pointer, tail pointer (IDW bits, natural wrap), count (IDW+1 bits).
- Reset (async, rst_ni low): all entry fields = 0; head = tail = count = 0.
  - Outputs then read: issue_ready_o = 1, issue_trans_id_o = 0, commit_valid_o = 0, commit_payload_o = 0, commit_data_o = 0, commit_ex_o = 0, occupancy_o = 0.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.
  - issue_ready_o = (count < NR_ENTRIES); issue_trans_id_o = tail; occupancy_o = count.
- Issue: on issue_valid_i & issue_ready_o & !flush_i:
  - entry[tail] gets busy=1, done=0, ex=0, payload captured;
  - tail increments by 1.
  - issue_valid_i while not ready is ignored; no state change.
- Full: a commit in the same cycle does NOT free the slot for an issue in that cycle. Issue is accepted from the next cycle.
- Writeback: for each port p with wb_valid_i[p], if entry[id] is busy:
  - set done=1, store data, store ex.
  - Writeback to a non-busy entry is dropped silently; this includes an entry being issued in the same cycle.
  - Two ports targeting the same ID in one cycle: the highest-index port wins.
  - A second writeback to an already-done entry overwrites it.
- Commit visibility: port k maps to entry[head+k] (mod NR_ENTRIES).
  - commit_valid_o[0] = busy & done of entry[head].
  - commit_valid_o[1] = commit_valid_o[0] & !ex(head) & busy & done of entry[head+1], so an exception retires alone on port 0.
  - Commit uses registered done only: writeback at cycle t makes commit_valid_o visible at t+1.
- Commit ack: the acknowledge vector is prefix-qualified.
  - Port 1 counts only if ack[0] is set and commit_valid_o[1] is set.
  - An ack on a port without valid is ignored.
  - Popped entries are cleared (busy=0, done=0); head advances by the number of popped entries.
- Count update: count_next = count + issued - popped. Simultaneous issue and commit is legal.
- Pointer wrap: modulo NR_ENTRIES; an ID is reused after wrap.
- Flush: highest priority in its cycle.
  - All busy/done/ex clear; head = tail = count = 0.
  - Issue, writeback and commit ack in the same cycle are discarded.
  - Outputs reflect the empty state from the next cycle.
- Reset mid-operation: immediate return to the reset state, regardless of in-flight entries.

Test Plan:
- Reset, then issue 3 payloads (0xA, 0xB, 0xC) -> issue_trans_id_o reads 0, 1, 2; occupancy_o = 3; commit_valid_o = 0.
- Writeback ID 1 and then ID 0 (data 0x11, 0x10) at cycles t, t+1; ack both ports at t+2 -> at t+2 commit_valid_o = 2'b11 with data 0x10 and 0x11; occupancy_o = 1 after the ack.
- Fill 8 entries -> issue_ready_o = 0. Issue held while committing 2 in one cycle -> no issue that cycle; issue accepted the next cycle with ID 0 after wrap; occupancy_o = 7.
- Head entry written back with wb_ex_i = 1 and head+1 done -> commit_valid_o = 2'b01, commit_ex_o[0] = 1; ack = 2'b11 pops only 1 entry.
- Both writeback ports hit ID 2 in the same cycle (data 0x20, 0x21) -> stored data is 0x21. A writeback to a free ID changes nothing.
- Flush with 5 entries busy, coinciding with an issue and a commit ack -> next cycle occupancy_o = 0, issue_trans_id_o = 0, commit_valid_o = 0. Assert rst_ni low mid-stream -> same empty state immediately.

Source files
------------

// File: rtl/retire_scoreboard.sv
// retire_scoreboard: in-order circular-buffer scoreboard between issue and commit.
// Issue allocates at the tail, functional units write back out of order by ID,
// and commit retires up to NR_COMMIT_PORTS of the oldest completed entries per cycle.
//
// Handshake semantics (all three interfaces):
//   issue  : an entry is allocated on a cycle where issue_valid_i & issue_ready_o & !flush_i;
//            issue_trans_id_o names the allocated slot and is valid whenever issue_ready_o is high.
//   wb     : wb_valid_i[p] is a fire-and-forget strobe; it lands only if the target entry is busy.
//   commit : port k pops its entry when commit_valid_o[k] & commit_ack_i[k] and every lower
//            port also pops (prefix rule); acks without valid are ignored.
// All outputs are decoded from registered state only.
module retire_scoreboard #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 2,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned PAYLOAD_W       = 32,
    parameter int unsigned IDW             = $clog2(NR_ENTRIES)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             issue_valid_i,
    input  logic [PAYLOAD_W-1:0]             issue_payload_i,
    output logic                             issue_ready_o,
    output logic [IDW-1:0]                   issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]           wb_valid_i,
    input  logic [NR_WB_PORTS*IDW-1:0]       wb_trans_id_i,
    input  logic [NR_WB_PORTS*XLEN-1:0]      wb_data_i,
    input  logic [NR_WB_PORTS-1:0]           wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]       commit_valid_o,
    output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0] commit_payload_o,
    output logic [NR_COMMIT_PORTS*XLEN-1:0]  commit_data_o,
    output logic [NR_COMMIT_PORTS-1:0]       commit_ex_o,
    input  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i,
    output logic [IDW:0]                     occupancy_o
);

    // Per-entry storage
    logic [NR_ENTRIES-1:0]  busy_q;
    logic [NR_ENTRIES-1:0]  done_q;
    logic [NR_ENTRIES-1:0]  ex_q;
    logic [PAYLOAD_W-1:0]   payload_q [NR_ENTRIES];
    logic [XLEN-1:0]        data_q    [NR_ENTRIES];

    // Ring pointers and occupancy
    logic [IDW-1:0] head_q;
    logic [IDW-1:0] tail_q;
    logic [IDW:0]   count_q;

    logic                       issue_fire;
    logic [IDW-1:0]             commit_idx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] pop;
    logic [IDW:0]               n_pop;
    logic                       valid_chain;
    logic                       pop_chain;

    // Issue side: ready only while a slot is free; a same-cycle commit does not help
    always_comb begin
        issue_ready_o    = (count_q < (IDW+1)'(NR_ENTRIES));
        issue_trans_id_o = tail_q;
        occupancy_o      = count_q;
        issue_fire       = issue_valid_i & issue_ready_o & ~flush_i;
    end

    // Commit window: port k looks at head+k; an exception stops the chain after itself
    always_comb begin
        commit_valid_o   = '0;
        commit_payload_o = '0;
        commit_data_o    = '0;
        commit_ex_o      = '0;
        valid_chain      = 1'b1;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            commit_idx[k] = head_q + IDW'(k);
            commit_valid_o[k] = valid_chain & busy_q[commit_idx[k]] & done_q[commit_idx[k]];
            commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[commit_idx[k]];
            commit_data_o[k*XLEN +: XLEN] = data_q[commit_idx[k]];
            commit_ex_o[k] = ex_q[commit_idx[k]];
            valid_chain = commit_valid_o[k] & ~ex_q[commit_idx[k]];
        end
    end

    // Prefix-qualified pop: a port retires only if every lower port retires too
    always_comb begin
        pop       = '0;
        n_pop     = '0;
        pop_chain = 1'b1;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            pop[k]    = pop_chain & commit_ack_i[k] & commit_valid_o[k];
            pop_chain = pop[k];
            n_pop     = n_pop + (IDW+1)'(pop[k]);
        end
    end

    // State update; later assignments take precedence (higher wb port, then pop, then issue)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            done_q  <= '0;
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                payload_q[i] <= '0;
                data_q[i]    <= '0;
            end
        end else if (flush_i) begin
            busy_q  <= '0;
            done_q  <= '0;
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
                if (wb_valid_i[p] && busy_q[wb_trans_id_i[p*IDW +: IDW]]) begin
                    done_q[wb_trans_id_i[p*IDW +: IDW]] <= 1'b1;
                    ex_q[wb_trans_id_i[p*IDW +: IDW]]   <= wb_ex_i[p];
                    data_q[wb_trans_id_i[p*IDW +: IDW]] <= wb_data_i[p*XLEN +: XLEN];
                end
            end
            for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
                if (pop[k]) begin
                    busy_q[commit_idx[k]] <= 1'b0;
                    done_q[commit_idx[k]] <= 1'b0;
                end
            end
            if (issue_fire) begin
                busy_q[tail_q]    <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                ex_q[tail_q]      <= 1'b0;
                payload_q[tail_q] <= issue_payload_i;
            end
            head_q  <= head_q + n_pop[IDW-1:0];
            tail_q  <= tail_q + IDW'(issue_fire);
            count_q <= count_q + (IDW+1)'(issue_fire) - n_pop;
        end
    end

endmodule
